// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - multi-cycle issue sequencer for the combinational EXU divider
//
// Latches one divide request and holds its operands on the divider for
// LATENCY cycles. RISC-V divide-by-zero and signed-overflow results are
// produced locally. The registered quotient is handed downstream through a
// valid/ready handshake.
//
// Parameters:
//   LATENCY      cycles the operands sit on the divider before sampling (1..15)
// Optional build macro:
//   DIV_ISSUE_FAST_ONE_EN  treat divisor == 1 as a 1-cycle special case
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 abort any in-flight operation
//   in_valid/in_ready     request handshake; in_src1, in_src2, in_ctrl operands/op
//   div_src1/2, div_ctrl  latched operands/op driven to the divider
//   div_result            divider output (already sign-extended for W ops)
//   out_valid/out_ready   result handshake; out_result final quotient
module div_issue_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_src1,
    input  logic [63:0] in_src2,
    input  logic [4:0]  in_ctrl,
    output logic [63:0] div_src1,
    output logic [63:0] div_src2,
    output logic [4:0]  div_ctrl,
    input  logic [63:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result
);

    localparam logic [4:0] OP_DIVW  = 5'b10001;
    localparam logic [4:0] OP_DIVUW = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;

    logic        op_legal;
    logic        accept;
    logic        is_w;
    logic        div_zero;
    logic        ovf;
    logic        special;
    logic [63:0] special_val;

    assign op_legal = (in_ctrl == OP_DIVW) || (in_ctrl == OP_DIVUW) ||
                      (in_ctrl == OP_DIVU) || (in_ctrl == OP_DIV);

    // flush wins over acceptance: a request in a flush cycle is not latched
    assign accept = (state == IDLE) && in_valid && op_legal && !flush;

    // Special cases are judged on the latched operands during the first
    // CALC cycle, which gives them a one-cycle latency.
    assign is_w     = (div_ctrl == OP_DIVW) || (div_ctrl == OP_DIVUW);
    assign div_zero = is_w ? (div_src2[31:0] == 32'd0) : (div_src2 == 64'd0);
    assign ovf      = ((div_ctrl == OP_DIV) &&
                       (div_src1 == 64'h8000_0000_0000_0000) &&
                       (div_src2 == 64'hFFFF_FFFF_FFFF_FFFF)) ||
                      ((div_ctrl == OP_DIVW) &&
                       (div_src1[31:0] == 32'h8000_0000) &&
                       (div_src2[31:0] == 32'hFFFF_FFFF));

`ifdef DIV_ISSUE_FAST_ONE_EN
    logic div_one;
    assign div_one = is_w ? (div_src2[31:0] == 32'd1) : (div_src2 == 64'd1);
    assign special = div_zero || ovf || div_one;
`else
    assign special = div_zero || ovf;
`endif

    always_comb begin
        special_val = 64'hFFFF_FFFF_FFFF_FFFF;
        if (div_zero) begin
            special_val = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (ovf) begin
            special_val = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        end else begin
            // divisor of one: quotient is the dividend
            special_val = is_w ? {{32{div_src1[31]}}, div_src1[31:0]} : div_src1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: if (special || (counter == 4'd0)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand latch, hold counter and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_src1   <= 64'd0;
            div_src2   <= 64'd0;
            div_ctrl   <= 5'd0;
            counter    <= 4'd0;
            out_result <= 64'd0;
        end else begin
            if (accept) begin
                div_src1 <= in_src1;
                div_src2 <= in_src2;
                div_ctrl <= in_ctrl;
                counter  <= 4'(LATENCY - 1);
            end else if ((state == CALC) && !flush) begin
                if (special) begin
                    out_result <= special_val;
                end else if (counter == 4'd0) begin
                    out_result <= div_result;
                end else begin
                    counter <= counter - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

    localparam int LAT = 4;
    localparam logic [4:0] OP_DIVW  = 5'b10001;
    localparam logic [4:0] OP_DIVUW = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_ctrl;
    logic [63:0] div_src1;
    logic [63:0] div_src2;
    logic [4:0]  div_ctrl;
    logic [63:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    int tests = 0;
    int fails = 0;

    div_issue_ctrl #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_ctrl    (in_ctrl),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_ctrl   (div_ctrl),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    // Behavioural divider; special-case operands never reach it legitimately,
    // so they simply yield zero here.
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    always_comb begin
        div_result = 64'd0;
        sa32 = div_src1[31:0];
        sb32 = div_src2[31:0];
        sa64 = div_src1;
        sb64 = div_src2;
        case (div_ctrl)
            OP_DIVU:  if (div_src2 != 64'd0) div_result = div_src1 / div_src2;
            OP_DIV:   if (div_src2 != 64'd0 && sb64 != -64'sd1) div_result = sa64 / sb64;
            OP_DIVUW: if (div_src2[31:0] != 32'd0)
                          div_result = {{32{1'b0}}, div_src1[31:0] / div_src2[31:0]};
            OP_DIVW:  if (sb32 != 32'sd0 && sb32 != -32'sd1) begin
                          div_result[31:0]  = sa32 / sb32;
                          div_result[63:32] = {32{div_result[31]}};
                      end
            default:  div_result = 64'd0;
        endcase
        if (div_ctrl == OP_DIVUW) div_result[63:32] = {32{div_result[31]}};
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request with out_ready=1 and check latency, result and handoff.
    task automatic run_op(input logic [63:0] s1, input logic [63:0] s2,
                          input logic [4:0] c, input logic [63:0] exp,
                          input int exp_lat, input string nm);
        int lat;
        lat = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_src1   = s1;
        in_src2   = s2;
        in_ctrl   = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s in_ready_after_accept got=%b exp=0", nm, in_ready);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests++;
        if (lat != exp_lat) begin
            fails++;
            $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat);
        end
        tests++;
        if (out_result !== exp) begin
            fails++;
            $display("FAIL %s result got=%h exp=%h", nm, out_result, exp);
        end
        tests++;
        if (div_src1 !== s1 || div_src2 !== s2 || div_ctrl !== c) begin
            fails++;
            $display("FAIL %s div_hold got=%h/%h/%b exp=%h/%h/%b", nm,
                     div_src1, div_src2, div_ctrl, s1, s2, c);
        end
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s after_handoff in_ready=%b out_valid=%b exp=1/0",
                     nm, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0 ||
            div_src1 !== 64'd0 || div_src2 !== 64'd0 || div_ctrl !== 5'd0) begin
            fails++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h s1=%h s2=%h c=%b exp=1/0/0/0/0/0",
                     in_ready, out_valid, out_result, div_src1, div_src2, div_ctrl);
        end
    endtask

    task automatic test_normal();
        run_op(64'd100, 64'd7, OP_DIVU, 64'd14, LAT, "divu_100_7");
        run_op(64'hFFFF_FFFF_FFFF_FFEC, 64'd3, OP_DIV, 64'hFFFF_FFFF_FFFF_FFFA, LAT, "div_m20_3");
    endtask

    task automatic test_special();
        run_op(64'd55, 64'd0, OP_DIV, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by_zero");
        run_op(64'd55, 64'hFFFF_FFFF_0000_0000, OP_DIVUW, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divuw_by_zero");
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV,
               64'h8000_0000_0000_0000, 1, "div_overflow");
        run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, OP_DIVW,
               64'hFFFF_FFFF_8000_0000, 1, "divw_overflow");
    endtask

    task automatic test_backpressure();
        int hold_bad;
        hold_bad = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_src1   = 64'hFFFF_FFFF_FFFF_FFF9;
        in_src2   = 64'd2;
        in_ctrl   = OP_DIVW;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFFD) hold_bad++;
            @(negedge clk);
            if (k == 4) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (hold_bad != 0) begin
            fails++;
            $display("FAIL hold_stable bad_cycles=%0d exp=0", hold_bad);
        end
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_handoff out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_src1   = 64'd10;
        in_src2   = 64'd3;
        in_ctrl   = OP_DIVU;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (out_valid === 1'b1) seen++;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
        end
        tests++;
        if (div_src1 !== 64'd10 || div_src2 !== 64'd3) begin
            fails++;
            $display("FAIL flush_keeps_div got=%h/%h exp=a/3", div_src1, div_src2);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_no_valid got=%0d exp=0", seen);
        end
        run_op(64'd9, 64'd3, OP_DIVU, 64'd3, LAT, "divu_after_flush");
    endtask

    task automatic test_flush_priority();
        // flush during an offered request: request is not latched
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_src1  = 64'd77;
        in_src2  = 64'd7;
        in_ctrl  = OP_DIVU;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || div_src1 !== 64'd9) begin
            fails++;
            $display("FAIL flush_blocks_accept in_ready=%b div_src1=%h exp=1/9", in_ready, div_src1);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] prev1;
        int seen;
        seen  = 0;
        prev1 = div_src1;
        @(negedge clk);
        in_valid = 1'b1;
        in_src1  = 64'hDEAD;
        in_src2  = 64'h5;
        in_ctrl  = 5'b00011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || div_src1 !== prev1 || div_ctrl === 5'b00011) begin
            fails++;
            $display("FAIL illegal_op in_ready=%b div_src1=%h div_ctrl=%b exp=1/%h/not00011",
                     in_ready, div_src1, div_ctrl, prev1);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL illegal_no_valid got=%0d exp=0", seen);
        end
    endtask

    task automatic test_divisor_one();
`ifdef DIV_ISSUE_FAST_ONE_EN
        run_op(64'h0000_0000_8000_0001, 64'd1, OP_DIVW, 64'hFFFF_FFFF_8000_0001, 1, "divw_by_one");
        run_op(64'h1234_5678_9ABC_DEF0, 64'd1, OP_DIVU, 64'h1234_5678_9ABC_DEF0, 1, "divu_by_one");
`else
        run_op(64'h0000_0000_8000_0001, 64'd1, OP_DIVW, 64'hFFFF_FFFF_8000_0001, LAT, "divw_by_one");
        run_op(64'h1234_5678_9ABC_DEF0, 64'd1, OP_DIVU, 64'h1234_5678_9ABC_DEF0, LAT, "divu_by_one");
`endif
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_src1   = 64'd50;
        in_src2   = 64'd5;
        in_ctrl   = OP_DIVU;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0 ||
            div_src1 !== 64'd0 || div_src2 !== 64'd0 || div_ctrl !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid_op rdy=%b vld=%b res=%h s1=%h s2=%h c=%b exp=1/0/0/0/0/0",
                     in_ready, out_valid, out_result, div_src1, div_src2, div_ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_src1   = 64'd0;
        in_src2   = 64'd0;
        in_ctrl   = 5'd0;
        out_ready = 1'b1;
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_flush();
        test_flush_priority();
        test_illegal();
        test_divisor_one();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
